// File: rtl/led7seg_scan.sv
// led7seg_scan -- multiplexed 7-segment display scanner.
//
// Drives DIGITS common-select digits by time-multiplexing one shared
// segment bus. Each digit owns a slot of DIV clock cycles. The first GUARD
// cycles of every slot are dark, so the previous digit's pattern never
// ghosts onto the newly selected digit.
//
// Ports
//   CLK    in   1          sole clock, rising edge
//   RST_N  in   1          synchronous active-low reset
//   EN     in   1          scan enable; when low the scan freezes and the display is dark
//   LOAD   in   1          strobe: capture DATA/DP/BLANK into shadow registers
//   DATA   in   4*DIGITS   hex nibble per digit, digit 0 = rightmost = DATA[3:0]
//   DP     in   DIGITS     decimal point per digit
//   BLANK  in   DIGITS     force a digit dark, including its DP
//   LZS    in   1          leading-zero suppression (live, not shadowed)
//   LED    out  8          segments {dp,g,f,e,d,c,b,a}, registered
//   SA     out  DIGITS     digit select, one-hot or all inactive, registered
module led7seg_scan #(
    parameter int DIGITS         = 4,
    parameter int DIV            = 50000,
    parameter int GUARD          = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SA_ACTIVE_LOW  = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic [DIGITS-1:0]     DP,
    input  logic [DIGITS-1:0]     BLANK,
    input  logic                  LZS,
    output logic [7:0]            LED,
    output logic [DIGITS-1:0]     SA
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  GUARD_C = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        LED_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SA_OFF  = (SA_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Active-high segment pattern, bit order gfedcba.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [7:0]          led_q, led_d;
    logic [DIGITS-1:0]   sa_q, sa_d;

    logic                in_guard;
    logic [DIGITS-1:0]   lz_mask;
    logic [3:0]          nib_sel;
    logic                dp_sel;
    logic                blank_sel;
    logic                lz_sel;
    logic [7:0]          led_raw;
    logic [DIGITS-1:0]   sa_raw;

    // With GUARD=0 the guard window is empty; avoid a constant compare.
    if (GUARD > 0) begin : g_guard
        assign in_guard = (cnt_q < GUARD_C);
    end else begin : g_no_guard
        assign in_guard = 1'b0;
    end

    // Prescaler and digit index; both freeze while EN is low.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (EN) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        sh_data_d  = LOAD ? DATA  : sh_data_q;
        sh_dp_d    = LOAD ? DP    : sh_dp_q;
        sh_blank_d = LOAD ? BLANK : sh_blank_q;
    end

    // lz_mask[i] is set when digit i (i>0) and every digit to its left hold
    // zero. Digit 0 is excluded so a value of zero still shows "0".
    always_comb begin
        logic zero_run;
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (sh_data_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run && (i != 0);
        end
    end

    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        lz_sel    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel   = sh_data_q[4*i +: 4];
                dp_sel    = sh_dp_q[i];
                blank_sel = sh_blank_q[i];
                lz_sel    = lz_mask[i];
            end
        end
    end

    // Build the next output in active-high form, then apply polarity last so
    // every form of blanking ends up as the physical "off" level.
    always_comb begin
        led_raw = 8'h00;
        sa_raw  = '0;
        if (EN && !in_guard) begin
            sa_raw = DIGITS'(1) << idx_q;
            if (!blank_sel) begin
                // Suppression darkens a..g only; the decimal point stays live.
                led_raw = {dp_sel, (LZS && lz_sel) ? 7'h00 : hex_to_seg(nib_sel)};
            end
        end
        led_d = (SEG_ACTIVE_LOW != 0) ? ~led_raw : led_raw;
        sa_d  = (SA_ACTIVE_LOW != 0)  ? ~sa_raw  : sa_raw;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            led_q      <= LED_OFF;
            sa_q       <= SA_OFF;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            led_q      <= led_d;
            sa_q       <= sa_d;
        end
    end

    assign LED = led_q;
    assign SA  = sa_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// Directed bench for led7seg_scan: DIGITS=4, DIV=4, GUARD=1, both outputs
// active-low. Inputs change on the falling edge; outputs are read there too.
module tb_led7seg_scan;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN;
    logic        LOAD;
    logic [15:0] DATA;
    logic [3:0]  DP;
    logic [3:0]  BLANK;
    logic        LZS;
    logic [7:0]  LED;
    logic [3:0]  SA;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [11:0] OFF = {4'hF, 8'hFF};

    led7seg_scan #(
        .DIGITS(4), .DIV(4), .GUARD(1), .SEG_ACTIVE_LOW(1), .SA_ACTIVE_LOW(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .LOAD(LOAD), .DATA(DATA),
        .DP(DP), .BLANK(BLANK), .LZS(LZS), .LED(LED), .SA(SA)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got SA/LED=%h expected %h", tag, got, exp);
        end
    endtask

    // Called with output showing digit 0's guard cycle; checks one full frame
    // and returns at the same phase of the next frame.
    task automatic check_frame(input string tag, input logic [7:0] l0, input logic [7:0] l1,
                               input logic [7:0] l2, input logic [7:0] l3);
        logic [7:0] led_exp [4];
        logic [3:0] sa_exp  [4];
        led_exp = '{l0, l1, l2, l3};
        sa_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0)
                    chk($sformatf("%s d%0d guard", tag, k), {SA, LED}, OFF);
                else
                    chk($sformatf("%s d%0d c%0d", tag, k, c), {SA, LED}, {sa_exp[k], led_exp[k]});
                @(negedge CLK);
            end
        end
    endtask

    // Load new shadow values and wait a whole frame so the next frame is clean.
    task automatic load_and_align(input logic [15:0] d, input logic [3:0] dp,
                                  input logic [3:0] bl, input logic lz);
        DATA  = d;
        DP    = dp;
        BLANK = bl;
        LZS   = lz;
        LOAD  = 1'b1;
        @(negedge CLK);
        LOAD  = 1'b0;
        repeat (15) @(negedge CLK);
    endtask

    initial begin
        // Reset with EN and LOAD asserted: reset must win.
        RST_N = 1'b0; EN = 1'b1; LOAD = 1'b1;
        DATA = 16'h1234; DP = 4'h0; BLANK = 4'h0; LZS = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset outputs", {SA, LED}, OFF);

        // Release and load 1234 on the same edge.
        RST_N = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        check_frame("hex1234 f0", 8'h99, 8'hB0, 8'hA4, 8'hF9);
        check_frame("hex1234 f1", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        load_and_align(16'h00A0, 4'h0, 4'h0, 1'b1);
        check_frame("lzs on", 8'hC0, 8'h88, 8'hFF, 8'hFF);
        LZS = 1'b0;
        check_frame("lzs off", 8'hC0, 8'h88, 8'hC0, 8'hC0);

        load_and_align(16'h1234, 4'b0100, 4'b0001, 1'b0);
        check_frame("dp blank", 8'hFF, 8'hB0, 8'h24, 8'hF9);

        // Suppressed digit keeps its decimal point.
        load_and_align(16'h0005, 4'b1000, 4'b0000, 1'b1);
        check_frame("lzs dp", 8'h92, 8'hFF, 8'hFF, 8'h7F);

        // Enable drop during digit 2 at cnt=2.
        load_and_align(16'h1234, 4'h0, 4'h0, 1'b0);
        repeat (9) @(negedge CLK);
        chk("pre-drop d2", {SA, LED}, {4'b1011, 8'hA4});
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("en off %0d", i), {SA, LED}, OFF);
        end
        EN = 1'b1;
        @(negedge CLK); chk("resume d2 c2", {SA, LED}, {4'b1011, 8'hA4});
        @(negedge CLK); chk("resume d2 c3", {SA, LED}, {4'b1011, 8'hA4});
        @(negedge CLK); chk("resume d3 guard", {SA, LED}, OFF);
        @(negedge CLK); chk("resume d3", {SA, LED}, {4'b0111, 8'hF9});

        // One-cycle reset in the middle of digit 3.
        RST_N = 1'b0;
        @(negedge CLK); chk("midslot reset", {SA, LED}, OFF);
        RST_N = 1'b1;
        @(negedge CLK); chk("post-rst guard", {SA, LED}, OFF);
        @(negedge CLK); chk("post-rst d0 c1", {SA, LED}, {4'b1110, 8'hC0});
        @(negedge CLK); chk("post-rst d0 c2", {SA, LED}, {4'b1110, 8'hC0});

        // LOAD on the edge where the index moves to digit 1.
        DATA = 16'hFFFF; DP = 4'h0; BLANK = 4'h0; LOAD = 1'b1;
        @(negedge CLK); chk("post-rst d0 c3", {SA, LED}, {4'b1110, 8'hC0});
        LOAD = 1'b0;
        @(negedge CLK); chk("load d1 guard", {SA, LED}, OFF);
        @(negedge CLK); chk("load d1 c1", {SA, LED}, {4'b1101, 8'h8E});
        @(negedge CLK); chk("load d1 c2", {SA, LED}, {4'b1101, 8'h8E});
        @(negedge CLK); chk("load d1 c3", {SA, LED}, {4'b1101, 8'h8E});
        @(negedge CLK); chk("load d2 guard", {SA, LED}, OFF);
        @(negedge CLK); chk("load d2 c1", {SA, LED}, {4'b1011, 8'h8E});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/led7seg_scan.md
LED7SEG_SCAN -- requirements
Module: led7seg_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter DIV, default 50000: clock cycles per digit slot, DIV >= 2.
REQ-003 SHALL have parameter GUARD, default 1: anti-ghost off cycles at the start of each slot, 0 <= GUARD < DIV.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 = LED bits are driven low to light a segment.
REQ-005 SHALL have parameter SA_ACTIVE_LOW, default 1: 1 = SA bits are driven low to select a digit.
REQ-006 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-007 RST_N  input  1  reset, synchronous, active-low.
REQ-008 EN  input  1  scan enable.
REQ-009 LOAD  input  1  single-cycle strobe that latches DATA, DP and BLANK into shadow registers.
REQ-010 DATA  input  4*DIGITS  hex nibble per digit; digit i = DATA[4i+3:4i], digit 0 = rightmost.
REQ-011 DP  input  DIGITS  decimal point per digit.
REQ-012 BLANK  input  DIGITS  force digit i dark, including its DP.
REQ-013 LZS  input  1  leading-zero suppression enable, used live and not shadowed.
REQ-014 LED  output  8  segments: bit0 a, bit1 b, bit2 c, bit3 d, bit4 e, bit5 f, bit6 g, bit7 dp.
REQ-015 SA  output  DIGITS  digit select, one-hot or all-inactive.

Function
REQ-016 Shadow registers SHALL load DATA/DP/BLANK on a rising edge with LOAD=1 and hold otherwise; only the shadow copies drive the display.
REQ-017 Prescaler cnt SHALL count 0..DIV-1 while EN=1 and wrap to 0; digit index idx SHALL advance only on an edge where cnt=DIV-1, wrapping DIGITS-1 -> 0.
REQ-018 With EN=0, cnt and idx SHALL hold their values; LED and SA SHALL go inactive on the next edge.
REQ-019 LED and SA SHALL be registered: the output after edge t+1 reflects cnt, idx, shadow and LZS as sampled before edge t+1 (one-cycle latency).
REQ-020 While cnt < GUARD, SA SHALL be all-inactive and LED all-inactive; otherwise SA SHALL select bit idx only.
REQ-021 Decode, active-high gfedcba: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-022 dp SHALL equal shadow DP[idx]; digits with BLANK[idx]=1 SHALL output all-inactive LED while SA remains selected.
REQ-023 With LZS=1, digit i>0 SHALL have segments a..g dark when nibbles DIGITS-1..i are all zero; its dp SHALL still follow DP[i]; digit 0 SHALL never be suppressed.
REQ-024 Output polarity SHALL invert LED when SEG_ACTIVE_LOW=1 and SA when SA_ACTIVE_LOW=1, applied after all blanking; "inactive" means all-1 in active-low mode and all-0 otherwise.
REQ-025 A LOAD coinciding with a slot change SHALL take effect in the same registered output as that change.
REQ-026 With DIGITS=1, idx SHALL stay 0 and SA SHALL pulse per GUARD only.

Reset
REQ-027 On an edge with RST_N=0: cnt=0, idx=0, shadow registers all 0, LED inactive, SA inactive; this takes priority over EN and LOAD.
REQ-028 Reset asserted mid-slot SHALL abort the slot; the first slot after release SHALL be digit 0, starting at cnt=0.

Verification
REQ-029 DIGITS=4, DIV=4, GUARD=1, both active-low, LOAD DATA=16'h1234, DP=0, EN=1 -> per 4-cycle slot: 1 cycle SA=1111/LED=FF, then 3 cycles SA=1110/LED=0x99 (digit 4), then SA=1101/LED=0xB0 (digit 3), SA=1011/LED=0xA4 (digit 2), SA=0111/LED=0xF9 (digit 1); sequence repeats.
REQ-030 DATA=16'h00A0, LZS=1 -> digits 3 and 2 show LED=0xFF with SA selected; digit 1 shows 0x88 (A); digit 0 shows 0xC0 (0); with LZS=0, digits 3 and 2 show 0xC0.
REQ-031 DP=4'b0100, BLANK=4'b0001 -> digit 2 LED bit7=0; digit 0 LED=0xFF for the whole slot.
REQ-032 EN dropped during digit 2 slot at cnt=2, held 5 cycles, then raised -> outputs inactive 1 cycle after the drop; on re-enable, digit 2 resumes at cnt=2 and advances after 2 more cycles.
REQ-033 RST_N low for 1 cycle during digit 3 slot -> next outputs SA=1111/LED=FF; shadow cleared so digit 0 shows 0xC0; scan restarts at digit 0.
REQ-034 LOAD 16'hFFFF applied on the edge where digit 1 begins -> the first non-guard cycle of digit 1 shows 0x8E (F), with no stale value visible.
